// File: rtl/rv2t_csr_mmode_pkg.sv
// Shared constants for the machine-mode CSR block: CSR addresses, write
// operation encodings, interrupt cause codes, mstatus bit positions and
// the fixed identification values.
package rv2t_csr_mmode_pkg;

   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MIE           = 12'h304;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MTVAL         = 12'h343;
   localparam logic [11:0] CSR_MIP           = 12'h344;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
   localparam logic [11:0] CSR_MARCHID       = 12'hF12;
   localparam logic [11:0] CSR_MIMPID        = 12'hF13;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;

   typedef enum logic [1:0] {
      WOP_WRITE = 2'b00,
      WOP_SET   = 2'b01,
      WOP_CLEAR = 2'b10,
      WOP_RSVD  = 2'b11
   } wop_e;

   localparam logic [4:0] IRQ_MSI       = 5'd3;
   localparam logic [4:0] IRQ_MTI       = 5'd7;
   localparam logic [4:0] IRQ_MEI       = 5'd11;
   localparam int         IRQ_PLAT_BASE = 16;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;

   localparam logic [31:0] ID_VENDOR = 32'h0000_0000;
   localparam logic [31:0] ID_ARCH   = 32'h0000_0000;
   localparam logic [31:0] ID_IMP    = 32'h0000_0001;
   localparam logic [31:0] ID_HART   = 32'h0000_0000;
   // misa extension field: base integer ISA only (bit 8, 'I')
   localparam logic [25:0] MISA_EXT  = 26'h000_0100;

endpackage

// File: rtl/rv2t_csr_counter.sv
// Free-running CSR counter (mcycle / minstret style). Low and high XLEN
// halves are separately writable; a write wins over the same-cycle increment.
module rv2t_csr_counter
   import rv2t_csr_mmode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int WIDTH = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            sync_reset,
   input  logic            i_inc,
   input  logic            i_inhibit,
   input  logic            i_wr_lo,
   input  logic            i_wr_hi,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_lo,
   output logic [XLEN-1:0] o_hi
);

   localparam int HI_BITS = WIDTH - XLEN;

   logic [WIDTH-1:0] r_count;
   // Upper operand bits are dropped when the counter is narrower than 2*XLEN
   logic             w_unused_wdata;

   assign w_unused_wdata = ^i_wdata;

   // Count, with half-word writes overriding the increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (sync_reset) begin
         r_count <= '0;
      end else if (i_wr_lo) begin
         r_count[XLEN-1:0] <= i_wdata;
      end else if (i_wr_hi) begin
         r_count[WIDTH-1:XLEN] <= i_wdata[HI_BITS-1:0];
      end else if (i_inc && !i_inhibit) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_lo = r_count[XLEN-1:0];
   assign o_hi = XLEN'(r_count[WIDTH-1:XLEN]);

endmodule

// File: rtl/rv2t_csr_mmode.sv
// Machine-mode CSR file for a small RV32 core: trap entry/return, interrupt
// pending/enable with cause selection, mtvec target computation and the
// cycle/instret counters. Reads are registered (one cycle latency); any
// illegal access suppresses both the read response and the write.
module rv2t_csr_mmode
   import rv2t_csr_mmode_pkg::*;
#(
   parameter int XLEN             = 32,
   parameter int COUNTER_BITS     = 64,
   parameter int NUM_PLATFORM_IRQ = 4,
   parameter int VECTORED_EN      = 1,
   localparam int PIRQ_W          = (NUM_PLATFORM_IRQ > 0) ? NUM_PLATFORM_IRQ : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sync_reset,
   input  logic              exe_enable,
   input  logic              read_enable,
   input  logic [11:0]       read_addr,
   output logic              read_en_out,
   output logic [XLEN-1:0]   read_data_out,
   input  logic              write_enable,
   input  logic [11:0]       write_addr,
   input  logic [XLEN-1:0]   write_data_in,
   input  logic [1:0]        write_op,
   input  logic              timer_triggered,
   input  logic              sw_irq,
   input  logic              ext_irq,
   input  logic [PIRQ_W-1:0] platform_irq,
   input  logic              activate_exception,
   input  logic              is_interrupt,
   input  logic [3:0]        exception_code,
   input  logic [XLEN-1:0]   exception_PC,
   input  logic [XLEN-1:0]   exception_addr,
   input  logic              mret,
   output logic              illegal_access,
   output logic [XLEN-1:0]   mtvec_out,
   output logic [XLEN-1:0]   mepc_out,
   output logic [XLEN-1:0]   trap_addr_out,
   output logic              irq_req_out,
   output logic [4:0]        irq_code_out
);

   localparam logic [XLEN-1:0] PLAT_MASK =
      ((XLEN'(1) << NUM_PLATFORM_IRQ) - XLEN'(1)) << IRQ_PLAT_BASE;
   localparam logic [XLEN-1:0] MIE_MASK = XLEN'(32'h0000_0888) | PLAT_MASK;
   localparam logic [XLEN-1:0] MISA_VAL = (XLEN'(1) << (XLEN - 2)) | XLEN'(MISA_EXT);

   logic            r_mstatus_mie;
   logic            r_mstatus_mpie;
   logic [XLEN-1:0] r_mie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_mtval;
   logic            r_mtip;
   logic            r_timer_q;
   logic            r_inhibit_cy;
   logic            r_inhibit_ir;
   logic            r_rd_en;
   logic [XLEN-1:0] r_rd_data;
   logic            r_illegal;

   logic [XLEN-1:0] w_mstatus;
   logic [XLEN-1:0] w_mip;
   logic [XLEN-1:0] w_mcountinhibit;
   logic [XLEN-1:0] w_cy_lo, w_cy_hi, w_ir_lo, w_ir_hi;
   logic [XLEN:0]   w_rd_lookup;
   logic [XLEN:0]   w_wr_lookup;
   logic            w_rw_slot;
   logic            w_rd_req, w_wr_req;
   logic            w_wr_legal;
   logic            w_illegal;
   logic            w_rd_fire, w_wr_fire;
   logic [XLEN-1:0] w_wr_old;
   logic [XLEN-1:0] w_wr_value;
   logic            w_timer_rise;
   logic [XLEN-1:0] w_pend;
   logic [XLEN-1:0] w_base;

   // Returns {implemented, current value} for a CSR address
   function automatic logic [XLEN:0] csr_lookup(input logic [11:0] addr);
      logic [XLEN:0] res;
      res = '0;
      case (addr)
         CSR_MVENDORID:     res = {1'b1, XLEN'(ID_VENDOR)};
         CSR_MARCHID:       res = {1'b1, XLEN'(ID_ARCH)};
         CSR_MIMPID:        res = {1'b1, XLEN'(ID_IMP)};
         CSR_MHARTID:       res = {1'b1, XLEN'(ID_HART)};
         CSR_MISA:          res = {1'b1, MISA_VAL};
         CSR_MSTATUS:       res = {1'b1, w_mstatus};
         CSR_MIE:           res = {1'b1, r_mie};
         CSR_MIP:           res = {1'b1, w_mip};
         CSR_MTVEC:         res = {1'b1, r_mtvec};
         CSR_MSCRATCH:      res = {1'b1, r_mscratch};
         CSR_MEPC:          res = {1'b1, r_mepc};
         CSR_MCAUSE:        res = {1'b1, r_mcause};
         CSR_MTVAL:         res = {1'b1, r_mtval};
         CSR_MCOUNTINHIBIT: res = {1'b1, w_mcountinhibit};
         CSR_MCYCLE:        res = {1'b1, w_cy_lo};
         CSR_MCYCLEH:       res = {1'b1, w_cy_hi};
         CSR_MINSTRET:      res = {1'b1, w_ir_lo};
         CSR_MINSTRETH:     res = {1'b1, w_ir_hi};
         default:           res = '0;
      endcase
      return res;
   endfunction

   // Read-only views assembled from live inputs and stored bits
   always_comb begin
      w_mstatus                   = '0;
      w_mstatus[12:11]            = 2'b11;
      w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
      w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;
      w_mcountinhibit             = '0;
      w_mcountinhibit[0]          = r_inhibit_cy;
      w_mcountinhibit[2]          = r_inhibit_ir;
      w_mip                       = '0;
      w_mip[3]                    = sw_irq;
      w_mip[7]                    = r_mtip;
      w_mip[11]                   = ext_irq;
      for (int i = 0; i < NUM_PLATFORM_IRQ; i++) begin
         w_mip[IRQ_PLAT_BASE + i] = platform_irq[i];
      end
   end

   // Request arbitration: trap entry and mret pre-empt CSR accesses
   always_comb begin
      w_rd_lookup = csr_lookup(read_addr);
      w_wr_lookup = csr_lookup(write_addr);
      w_rw_slot   = !activate_exception && !mret;
      w_rd_req    = w_rw_slot && read_enable;
      w_wr_req    = w_rw_slot && write_enable;
      w_wr_legal  = w_wr_lookup[XLEN] && (write_addr[11:10] != 2'b11);
      w_illegal   = (w_rd_req && !w_rd_lookup[XLEN]) || (w_wr_req && !w_wr_legal);
      w_rd_fire   = w_rd_req && !w_illegal;
      w_wr_fire   = w_wr_req && !w_illegal;
      w_wr_old    = w_wr_lookup[XLEN-1:0];
   end

   // CSRRW / CSRRS / CSRRC operand merge; reserved encoding behaves as write
   always_comb begin
      w_wr_value = write_data_in;
      case (wop_e'(write_op))
         WOP_SET:   w_wr_value = w_wr_old | write_data_in;
         WOP_CLEAR: w_wr_value = w_wr_old & ~write_data_in;
         default:   w_wr_value = write_data_in;
      endcase
   end

   assign w_timer_rise = timer_triggered && !r_timer_q;

   // mstatus interrupt-enable stack: trap pushes, mret pops, else CSR write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
      end else if (sync_reset) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
      end else if (activate_exception) begin
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
      end else if (mret) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else if (w_wr_fire && write_addr == CSR_MSTATUS) begin
         r_mstatus_mie  <= w_wr_value[MSTATUS_MIE_BIT];
         r_mstatus_mpie <= w_wr_value[MSTATUS_MPIE_BIT];
      end
   end

   // Trap-cause registers: loaded on trap entry, otherwise CSR-writable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mepc   <= '0;
         r_mcause <= '0;
         r_mtval  <= '0;
      end else if (sync_reset) begin
         r_mepc   <= '0;
         r_mcause <= '0;
         r_mtval  <= '0;
      end else if (activate_exception) begin
         r_mepc   <= {exception_PC[XLEN-1:1], 1'b0};
         r_mcause <= {is_interrupt, {(XLEN-5){1'b0}}, exception_code};
         r_mtval  <= exception_addr;
      end else if (w_wr_fire) begin
         if (write_addr == CSR_MEPC)   r_mepc   <= {w_wr_value[XLEN-1:1], 1'b0};
         if (write_addr == CSR_MCAUSE) r_mcause <= w_wr_value;
         if (write_addr == CSR_MTVAL)  r_mtval  <= w_wr_value;
      end
   end

   // Plain configuration CSRs; mtvec mode is WARL (only direct or vectored)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mie        <= '0;
         r_mtvec      <= '0;
         r_mscratch   <= '0;
         r_inhibit_cy <= 1'b0;
         r_inhibit_ir <= 1'b0;
      end else if (sync_reset) begin
         r_mie        <= '0;
         r_mtvec      <= '0;
         r_mscratch   <= '0;
         r_inhibit_cy <= 1'b0;
         r_inhibit_ir <= 1'b0;
      end else if (w_wr_fire) begin
         if (write_addr == CSR_MIE) r_mie <= w_wr_value & MIE_MASK;
         if (write_addr == CSR_MTVEC) begin
            r_mtvec <= {w_wr_value[XLEN-1:2],
                        (VECTORED_EN != 0 && w_wr_value[1:0] == 2'b01) ? 2'b01 : 2'b00};
         end
         if (write_addr == CSR_MSCRATCH) r_mscratch <= w_wr_value;
         if (write_addr == CSR_MCOUNTINHIBIT) begin
            r_inhibit_cy <= w_wr_value[0];
            r_inhibit_ir <= w_wr_value[2];
         end
      end
   end

   // MTIP: set by a timer rising edge, which beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timer_q <= 1'b0;
         r_mtip    <= 1'b0;
      end else if (sync_reset) begin
         r_timer_q <= 1'b0;
         r_mtip    <= 1'b0;
      end else begin
         r_timer_q <= timer_triggered;
         if (w_timer_rise) begin
            r_mtip <= 1'b1;
         end else if (w_wr_fire && write_addr == CSR_MIP) begin
            r_mtip <= w_wr_value[7];
         end
      end
   end

   // Registered read response and illegal-access pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_en   <= 1'b0;
         r_rd_data <= '0;
         r_illegal <= 1'b0;
      end else if (sync_reset) begin
         r_rd_en   <= 1'b0;
         r_rd_data <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_rd_en   <= w_rd_fire;
         r_illegal <= w_illegal;
         if (w_rd_fire) r_rd_data <= w_rd_lookup[XLEN-1:0];
      end
   end

   rv2t_csr_counter #(.XLEN(XLEN), .WIDTH(COUNTER_BITS)) u_mcycle (
      .clk        (clk),
      .reset_n    (reset_n),
      .sync_reset (sync_reset),
      .i_inc      (1'b1),
      .i_inhibit  (r_inhibit_cy),
      .i_wr_lo    (w_wr_fire && write_addr == CSR_MCYCLE),
      .i_wr_hi    (w_wr_fire && write_addr == CSR_MCYCLEH),
      .i_wdata    (w_wr_value),
      .o_lo       (w_cy_lo),
      .o_hi       (w_cy_hi)
   );

   rv2t_csr_counter #(.XLEN(XLEN), .WIDTH(COUNTER_BITS)) u_minstret (
      .clk        (clk),
      .reset_n    (reset_n),
      .sync_reset (sync_reset),
      .i_inc      (exe_enable),
      .i_inhibit  (r_inhibit_ir),
      .i_wr_lo    (w_wr_fire && write_addr == CSR_MINSTRET),
      .i_wr_hi    (w_wr_fire && write_addr == CSR_MINSTRETH),
      .i_wdata    (w_wr_value),
      .o_lo       (w_ir_lo),
      .o_hi       (w_ir_hi)
   );

   // Interrupt request and cause: MEI > MSI > MTI > lowest platform line
   always_comb begin
      w_pend       = w_mip & r_mie;
      irq_req_out  = r_mstatus_mie && (|w_pend);
      irq_code_out = 5'd0;
      for (int i = NUM_PLATFORM_IRQ - 1; i >= 0; i--) begin
         if (w_pend[IRQ_PLAT_BASE + i]) irq_code_out = 5'(IRQ_PLAT_BASE + i);
      end
      if (w_pend[7])  irq_code_out = IRQ_MTI;
      if (w_pend[3])  irq_code_out = IRQ_MSI;
      if (w_pend[11]) irq_code_out = IRQ_MEI;
   end

   // Trap target: vectored offset applies to interrupts only
   always_comb begin
      w_base        = {r_mtvec[XLEN-1:2], 2'b00};
      trap_addr_out = w_base;
      if (r_mtvec[1:0] == 2'b01 && is_interrupt) begin
         trap_addr_out = w_base + XLEN'({exception_code, 2'b00});
      end
   end

   assign read_en_out    = r_rd_en;
   assign read_data_out  = r_rd_data;
   assign illegal_access = r_illegal;
   assign mtvec_out      = r_mtvec;
   assign mepc_out       = r_mepc;

endmodule

// File: tb/tb_rv2t_csr_mmode.sv
// Directed bench for rv2t_csr_mmode with hand-computed expected values.
module tb_rv2t_csr_mmode;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sync_reset;
   logic        exe_enable;
   logic        read_enable;
   logic [11:0] read_addr;
   logic        read_en_out;
   logic [31:0] read_data_out;
   logic        write_enable;
   logic [11:0] write_addr;
   logic [31:0] write_data_in;
   logic [1:0]  write_op;
   logic        timer_triggered, sw_irq, ext_irq;
   logic [3:0]  platform_irq;
   logic        activate_exception, is_interrupt;
   logic [3:0]  exception_code;
   logic [31:0] exception_PC, exception_addr;
   logic        mret;
   logic        illegal_access;
   logic [31:0] mtvec_out, mepc_out, trap_addr_out;
   logic        irq_req_out;
   logic [4:0]  irq_code_out;

   int n_tests = 0;
   int n_fail  = 0;

   rv2t_csr_mmode #(
      .XLEN(32), .COUNTER_BITS(64), .NUM_PLATFORM_IRQ(4), .VECTORED_EN(1)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .sync_reset         (sync_reset),
      .exe_enable         (exe_enable),
      .read_enable        (read_enable),
      .read_addr          (read_addr),
      .read_en_out        (read_en_out),
      .read_data_out      (read_data_out),
      .write_enable       (write_enable),
      .write_addr         (write_addr),
      .write_data_in      (write_data_in),
      .write_op           (write_op),
      .timer_triggered    (timer_triggered),
      .sw_irq             (sw_irq),
      .ext_irq            (ext_irq),
      .platform_irq       (platform_irq),
      .activate_exception (activate_exception),
      .is_interrupt       (is_interrupt),
      .exception_code     (exception_code),
      .exception_PC       (exception_PC),
      .exception_addr     (exception_addr),
      .mret               (mret),
      .illegal_access     (illegal_access),
      .mtvec_out          (mtvec_out),
      .mepc_out           (mepc_out),
      .trap_addr_out      (trap_addr_out),
      .irq_req_out        (irq_req_out),
      .irq_code_out       (irq_code_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] op);
      write_enable  = 1'b1;
      write_addr    = a;
      write_data_in = d;
      write_op      = op;
      tick();
      write_enable  = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      read_enable = 1'b1;
      read_addr   = a;
      tick();
      read_enable = 1'b0;
      chk_val(tag, read_data_out, exp);
   endtask

   initial begin
      reset_n = 1'b0; sync_reset = 1'b0; exe_enable = 1'b0;
      read_enable = 1'b0; read_addr = '0;
      write_enable = 1'b0; write_addr = '0; write_data_in = '0; write_op = 2'b00;
      timer_triggered = 1'b0; sw_irq = 1'b0; ext_irq = 1'b0; platform_irq = '0;
      activate_exception = 1'b0; is_interrupt = 1'b0; exception_code = '0;
      exception_PC = '0; exception_addr = '0; mret = 1'b0;

      repeat (3) tick();
      chk_val("rst_rd_en",   read_en_out,    0);
      chk_val("rst_rd_data", read_data_out,  0);
      chk_val("rst_illegal", illegal_access, 0);
      chk_val("rst_mtvec",   mtvec_out,      0);
      chk_val("rst_irq",     irq_req_out,    0);
      reset_n = 1'b1;
      tick();
      chk_val("post_rst_illegal", illegal_access, 0);

      rd_chk("mstatus_rst", 12'h300, 32'h0000_1800);

      // CSRRS mstatus: read returns pre-write value
      read_enable = 1'b1; read_addr = 12'h300;
      write_enable = 1'b1; write_addr = 12'h300; write_data_in = 32'h8; write_op = 2'b01;
      tick();
      read_enable = 1'b0; write_enable = 1'b0;
      chk_val("csrrs_old", read_data_out, 32'h0000_1800);
      chk_val("csrrs_rd_en", read_en_out, 1);
      rd_chk("mstatus_set", 12'h300, 32'h0000_1808);
      tick();
      chk_val("rd_en_pulse", read_en_out, 0);
      chk_val("rd_data_hold", read_data_out, 32'h0000_1808);

      // vectored interrupt trap
      csr_wr(12'h305, 32'h0000_1001, 2'b00);
      chk_val("mtvec_out", mtvec_out, 32'h0000_1001);
      activate_exception = 1'b1; is_interrupt = 1'b1; exception_code = 4'd7;
      exception_PC = 32'h0000_2003; exception_addr = 32'hDEAD_BEEF;
      #1;
      chk_val("trap_vec", trap_addr_out, 32'h0000_101C);
      tick();
      activate_exception = 1'b0;
      chk_val("mepc_out", mepc_out, 32'h0000_2002);
      rd_chk("mcause_irq", 12'h342, 32'h8000_0007);
      rd_chk("mtval", 12'h343, 32'hDEAD_BEEF);
      rd_chk("mstatus_trap", 12'h300, 32'h0000_1880);
      mret = 1'b1; tick(); mret = 1'b0;
      rd_chk("mstatus_mret", 12'h300, 32'h0000_1888);

      // trap + mret + CSR access in one cycle: only the trap takes effect
      activate_exception = 1'b1; mret = 1'b1; is_interrupt = 1'b0; exception_code = 4'd2;
      exception_PC = 32'h0000_4000;
      write_enable = 1'b1; write_addr = 12'h340; write_data_in = 32'h55; write_op = 2'b00;
      read_enable = 1'b1; read_addr = 12'h342;
      #1;
      chk_val("trap_direct", trap_addr_out, 32'h0000_1000);
      tick();
      activate_exception = 1'b0; mret = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
      chk_val("drop_illegal", illegal_access, 0);
      chk_val("drop_rd_en", read_en_out, 0);
      rd_chk("mcause_exc", 12'h342, 32'h0000_0002);
      rd_chk("mstatus_prio", 12'h300, 32'h0000_1880);
      rd_chk("mscratch_drop", 12'h340, 32'h0);
      mret = 1'b1; tick(); mret = 1'b0;
      rd_chk("mstatus_mret2", 12'h300, 32'h0000_1888);

      // mtvec WARL: mode 3 collapses to direct
      csr_wr(12'h305, 32'h0000_2003, 2'b00);
      rd_chk("mtvec_warl", 12'h305, 32'h0000_2000);

      // interrupt priority and MTIP behaviour
      csr_wr(12'h304, 32'h888, 2'b00);
      sw_irq = 1'b1; ext_irq = 1'b1; #1;
      chk_val("irq_req_mei", irq_req_out, 1);
      chk_val("irq_code_mei", irq_code_out, 11);
      ext_irq = 1'b0; #1;
      chk_val("irq_code_msi", irq_code_out, 3);
      sw_irq = 1'b0; #1;
      chk_val("irq_none", irq_req_out, 0);
      timer_triggered = 1'b1; tick();
      chk_val("irq_code_mti", irq_code_out, 7);
      rd_chk("mip_mtip", 12'h344, 32'h80);
      csr_wr(12'h344, 32'h80, 2'b10);
      rd_chk("mip_clr_level", 12'h344, 32'h0);
      timer_triggered = 1'b0; tick();
      timer_triggered = 1'b1;
      csr_wr(12'h344, 32'h80, 2'b10);
      rd_chk("mip_set_wins", 12'h344, 32'h80);
      timer_triggered = 1'b0;
      csr_wr(12'h344, 32'h80, 2'b10);
      rd_chk("mip_clr", 12'h344, 32'h0);
      csr_wr(12'h304, 32'h0003_0000, 2'b01);
      rd_chk("mie_plat", 12'h304, 32'h0003_0888);
      platform_irq = 4'b0110; #1;
      chk_val("irq_code_plat", irq_code_out, 17);
      chk_val("irq_req_plat", irq_req_out, 1);
      rd_chk("mip_plat", 12'h344, 32'h0006_0000);
      csr_wr(12'h300, 32'h8, 2'b10); #1;
      chk_val("irq_gated", irq_req_out, 0);
      platform_irq = 4'b0000;
      csr_wr(12'h304, 32'hFFFF_FFFF, 2'b00);
      rd_chk("mie_mask", 12'h304, 32'h000F_0888);

      // counters
      csr_wr(12'hB00, 32'hFFFF_FFFF, 2'b00);
      tick();
      rd_chk("mcycleh_carry", 12'hB80, 32'h1);
      csr_wr(12'hB00, 32'h50, 2'b00);
      rd_chk("mcycle_wr_prio", 12'hB00, 32'h50);
      csr_wr(12'hB82, 32'h0, 2'b00);
      csr_wr(12'hB02, 32'h0, 2'b00);
      exe_enable = 1'b1; repeat (3) tick(); exe_enable = 1'b0;
      rd_chk("minstret_cnt", 12'hB02, 32'h3);
      csr_wr(12'h320, 32'h7, 2'b00);
      rd_chk("mcountinhibit", 12'h320, 32'h5);
      exe_enable = 1'b1; repeat (3) tick(); exe_enable = 1'b0;
      rd_chk("minstret_inh", 12'hB02, 32'h3);
      csr_wr(12'hB00, 32'h100, 2'b00);
      tick(); tick();
      rd_chk("mcycle_inh", 12'hB00, 32'h100);
      csr_wr(12'h320, 32'h0, 2'b00);

      // illegal accesses
      csr_wr(12'hC00, 32'h5, 2'b00);
      chk_val("ill_wr_c00", illegal_access, 1);
      tick();
      chk_val("ill_pulse_end", illegal_access, 0);
      rd_chk("mtvec_rd", 12'h305, 32'h0000_2000);
      read_enable = 1'b1; read_addr = 12'h7FF; tick(); read_enable = 1'b0;
      chk_val("ill_rd_7ff", illegal_access, 1);
      chk_val("ill_rd_en", read_en_out, 0);
      chk_val("ill_rd_hold", read_data_out, 32'h0000_2000);
      csr_wr(12'hF11, 32'h1, 2'b00);
      chk_val("ill_wr_ro", illegal_access, 1);
      rd_chk("mvendorid", 12'hF11, 32'h0);

      // write operations and identification
      csr_wr(12'h340, 32'h1234, 2'b00);
      csr_wr(12'h340, 32'h0204, 2'b10);
      rd_chk("mscratch_clr", 12'h340, 32'h1030);
      csr_wr(12'h340, 32'hABCD, 2'b11);
      rd_chk("mscratch_rsvd", 12'h340, 32'hABCD);
      csr_wr(12'h301, 32'h0, 2'b00);
      chk_val("misa_wr_legal", illegal_access, 0);
      rd_chk("misa", 12'h301, 32'h4000_0100);
      rd_chk("mhartid", 12'hF14, 32'h0);

      // synchronous reset discards a pending read
      read_enable = 1'b1; read_addr = 12'h305; sync_reset = 1'b1;
      tick();
      read_enable = 1'b0; sync_reset = 1'b0;
      chk_val("srst_rd_en", read_en_out, 0);
      chk_val("srst_rd_data", read_data_out, 0);
      chk_val("srst_mtvec", mtvec_out, 0);
      tick();
      chk_val("srst_no_pulse", read_en_out, 0);
      rd_chk("srst_mstatus", 12'h300, 32'h0000_1800);

      // asynchronous reset during a trap request
      activate_exception = 1'b1; exception_PC = 32'h0000_5000;
      reset_n = 1'b0; #2;
      activate_exception = 1'b0; reset_n = 1'b1;
      tick();
      chk_val("arst_mepc", mepc_out, 0);
      chk_val("arst_illegal", illegal_access, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
